branch_target_table: RTL and testbench
======================================

# branch_target_table

Runtime-writable branch-target table for the fetch stage of the core. It replaces the fixed constant offset lookup with a parametrised table: DEPTH entries, each holding a D-bit offset plus a per-entry relative/absolute mode bit. A registered read port returns the resolved next-PC target one cycle after the request. On reset, an initialisation sequencer clears every entry to "hold PC".

## Interface
Parameters:
- D, 12, target/offset/PC width in bits
- AW, 6, index width
- DEPTH, 64, number of implemented entries; legal range 1..2**AW

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- busy  out  1  high while the init sequencer runs; table inaccessible
- rd_req  in  1  read request strobe
- rd_addr  in  AW  entry index to read
- pc  in  D  current PC, sampled with rd_req
- rd_valid  out  1  one-cycle pulse: target is valid
- target  out  D  resolved branch target
- wr_en  in  1  write strobe
- wr_addr  in  AW  entry index to write
- wr_data  in  D  offset (relative) or target (absolute), two's complement
- wr_abs  in  1  mode bit written with the entry: 1 = absolute, 0 = PC-relative

## Operation
- Storage: DEPTH × (D+1) bits, i.e. {abs, value}.
- FSM states: INIT, READY.
  - reset → INIT, init index = 0.
  - INIT: each cycle writes {0, 0} to entry[index] and increments index. After entry DEPTH-1 is written → READY.
  - READY: stays in READY until reset.
- busy = 1 in INIT and 0 in READY.
- Reads (READY only):
  - rd_req=1 captures entry[rd_addr] and pc.
  - Resolved target = abs ? value : (pc + value), computed modulo 2**D with wrap-around and no saturation.
- rd_addr ≥ DEPTH: reads as {0, 0}, so target = pc (hold PC).
- Writes (READY only): wr_en=1 writes {wr_abs, wr_data} to entry[wr_addr]. Writes with wr_addr ≥ DEPTH are dropped.
- During INIT:
  - rd_req and wr_en are ignored.
  - No rd_valid pulse is generated.
  - No entry is modified other than by the sequencer.
- Simultaneous read and write to the same address: behaviour is set by BTT_WR_BYPASS_EN (see Configuration). Different addresses proceed independently.
- Reset asserted mid-operation (INIT or READY):
  - Next edge: busy=1, rd_valid=0, target=0.
  - Init sequencer restarts at index 0.
  - Any in-flight read is discarded.

## Timing
- Reset values: busy=1, rd_valid=0, target=0, FSM=INIT, init index=0.
- Init duration:
  - The first edge with reset low writes entry 0.
  - The DEPTH-th edge writes entry DEPTH-1 and clears busy.
  - busy therefore reads 0 after exactly DEPTH edges following reset release.
- Read latency is 1 cycle:
  - A request sampled at edge N yields rd_valid=1 and target after edge N.
  - rd_valid is held for exactly one cycle unless rd_req repeats.
  - Back-to-back requests give one result per cycle.
- target holds its last value when rd_valid=0. It is cleared only by reset.
- Write latency: a write at edge N is visible to a read sampled at edge N+1.

## Configuration
- BTT_WR_BYPASS_EN defined: a same-cycle read and write to the same valid address forwards the write. target uses {wr_abs, wr_data} from that cycle.
- BTT_WR_BYPASS_EN undefined: a same-cycle read returns the old entry contents. The new value is visible from the next cycle.
- The macro has no effect on ports or on any other behaviour.

## Test plan
- Init: release reset with DEPTH=64 → busy high for exactly 64 cycles. Then a read of every index with pc=0x100 returns target=0x100.
- Relative read: write entry 16 = 14 with wr_abs=0, then read 16 with pc=0x050 → next cycle rd_valid=1, target=0x05E. Write entry 17 = -143 (0xF71), read with pc=0x020 → target=0xF91 (wraps modulo 2**12).
- Absolute read: write entry 3 = 0x2A0 with wr_abs=1, read with pc=0x7FF → target=0x2A0.
- Collision: write entry 5 = 7 (relative) and read entry 5 with pc=0x010 in the same cycle, after entry 5 previously held 2.
  - With BTT_WR_BYPASS_EN → target=0x017.
  - Without BTT_WR_BYPASS_EN → target=0x012.
  - Either way, the next read → 0x017.
- Out-of-range entry (DEPTH=40): write index 45 = 9, then read index 45 with pc=0x123 → target=0x123.
- Reset mid-operation and ignored accesses: assert reset the cycle after a read request → rd_valid stays 0, target=0, busy=1. wr_en and rd_req issued during the re-init are ignored. Afterwards, every entry reads back as hold PC.

Source files
------------

// File: rtl/branch_target_table.sv
// Runtime-writable branch-target table: DEPTH entries of {abs, value}, cleared to
// "hold PC" by an init sequencer after reset. Optional macro: BTT_WR_BYPASS_EN.
module branch_target_table #(
    parameter int D     = 12,
    parameter int AW    = 6,
    parameter int DEPTH = 64
) (
    input  logic          clk,
    input  logic          reset,
    output logic          busy,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    input  logic [D-1:0]  pc,
    output logic          rd_valid,
    output logic [D-1:0]  target,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [D-1:0]  wr_data,
    input  logic          wr_abs
);

    typedef enum logic {INIT, READY} state_t;

    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t          state_q;
    logic [AW-1:0]   init_idx_q;
    logic            busy_q;
    logic            rd_valid_q;
    logic [D-1:0]    target_q;
    logic [D:0]      mem [DEPTH];

    logic            rd_in_range;
    logic            wr_in_range;
    logic [D:0]      rd_entry;
    logic [D-1:0]    target_d;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [D:0]      mem_wdata;

    always_comb begin
        rd_in_range = {1'b0, rd_addr} < DEPTH_W;
        wr_in_range = {1'b0, wr_addr} < DEPTH_W;
        // Unimplemented indices behave as a cleared entry, i.e. hold PC.
        rd_entry = rd_in_range ? mem[rd_addr] : '0;
`ifdef BTT_WR_BYPASS_EN
        if (wr_en && wr_in_range && rd_in_range && (wr_addr == rd_addr)) begin
            rd_entry = {wr_abs, wr_data};
        end
`endif
        target_d = rd_entry[D] ? rd_entry[D-1:0] : (pc + rd_entry[D-1:0]);
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = init_idx_q;
        mem_wdata = '0;
        if (!reset) begin
            if (state_q == INIT) begin
                mem_we = 1'b1;
            end else if (wr_en && wr_in_range) begin
                mem_we    = 1'b1;
                mem_waddr = wr_addr;
                mem_wdata = {wr_abs, wr_data};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= INIT;
            init_idx_q <= '0;
            busy_q     <= 1'b1;
            rd_valid_q <= 1'b0;
            target_q   <= '0;
        end else begin
            case (state_q)
                INIT: begin
                    rd_valid_q <= 1'b0;
                    init_idx_q <= init_idx_q + 1'b1;
                    if (init_idx_q == LAST_IDX) begin
                        state_q <= READY;
                        busy_q  <= 1'b0;
                    end
                end
                READY: begin
                    rd_valid_q <= rd_req;
                    if (rd_req) begin
                        target_q <= target_d;
                    end
                end
                default: begin
                    state_q <= INIT;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign rd_valid = rd_valid_q;
    assign target   = target_q;

endmodule

// File: tb/tb_branch_target_table.sv
// Self-checking bench for branch_target_table: a DEPTH=64 and a DEPTH=40 instance
// share stimulus and are compared every cycle against a table-level model.
module tb_branch_target_table;
    localparam int D  = 12;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic [D-1:0]  pc;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [D-1:0]  wr_data;
    logic          wr_abs;
    logic          busy_a, busy_b, valid_a, valid_b;
    logic [D-1:0]  target_a, target_b;

    always #5 clk = ~clk;

    branch_target_table #(.D(D), .AW(AW), .DEPTH(64)) dut_a (
        .clk(clk), .reset(reset), .busy(busy_a),
        .rd_req(rd_req), .rd_addr(rd_addr), .pc(pc),
        .rd_valid(valid_a), .target(target_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_abs(wr_abs)
    );

    branch_target_table #(.D(D), .AW(AW), .DEPTH(40)) dut_b (
        .clk(clk), .reset(reset), .busy(busy_b),
        .rd_req(rd_req), .rd_addr(rd_addr), .pc(pc),
        .rd_valid(valid_b), .target(target_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_abs(wr_abs)
    );

    int checks = 0;
    int errors = 0;
    int dep [2] = '{64, 40};
    logic [D:0]   mdl [2][64];
    int           cyc [2] = '{0, 0};
    logic         exp_valid [2];
    logic [D-1:0] exp_target [2];
    int n_a, n_b;

    function automatic logic [D:0] entry(int k, logic [AW-1:0] a);
        return (int'(a) < dep[k]) ? mdl[k][a] : '0;
    endfunction

    // Table-level model: init takes DEPTH cycles, then reads/writes act on the table.
    task automatic model_update();
        logic [D:0] e;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                cyc[k] = 0;
                exp_valid[k] = 1'b0;
                exp_target[k] = '0;
                for (int i = 0; i < 64; i++) mdl[k][i] = '0;
            end else if (cyc[k] < dep[k]) begin
                cyc[k]++;
                exp_valid[k] = 1'b0;
            end else begin
                e = entry(k, rd_addr);
`ifdef BTT_WR_BYPASS_EN
                if (wr_en && (wr_addr == rd_addr) && (int'(wr_addr) < dep[k])) e = {wr_abs, wr_data};
`endif
                exp_valid[k] = rd_req;
                if (rd_req) exp_target[k] = e[D] ? e[D-1:0] : D'(pc + e[D-1:0]);
                if (wr_en && (int'(wr_addr) < dep[k])) mdl[k][wr_addr] = {wr_abs, wr_data};
            end
        end
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare();
        chk("busy_a",   32'(busy_a),   32'(cyc[0] < dep[0]));
        chk("busy_b",   32'(busy_b),   32'(cyc[1] < dep[1]));
        chk("valid_a",  32'(valid_a),  32'(exp_valid[0]));
        chk("valid_b",  32'(valid_b),  32'(exp_valid[1]));
        chk("target_a", 32'(target_a), 32'(exp_target[0]));
        chk("target_b", 32'(target_b), 32'(exp_target[1]));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
        compare();
    endtask

    task automatic idle();
        rd_req = 0; wr_en = 0; rd_addr = '0; wr_addr = '0; wr_data = '0; wr_abs = 0; pc = '0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [D-1:0] d, input logic abs);
        wr_en = 1; wr_addr = a; wr_data = d; wr_abs = abs;
        cycle();
        wr_en = 0;
        $display("write idx=%0d data=%h abs=%0b", a, d, abs);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [D-1:0] p);
        rd_req = 1; rd_addr = a; pc = p;
        cycle();
        rd_req = 0;
        $display("read  idx=%0d pc=%h -> a:%0b/%h b:%0b/%h", a, p, valid_a, target_a, valid_b, target_b);
    endtask

    initial begin
        idle();
        reset = 1;
        cycle();
        cycle();
        chk("rst_busy", 32'({busy_a, busy_b}), 32'h3);
        chk("rst_valid", 32'({valid_a, valid_b}), 32'h0);
        chk("rst_target", 32'(target_a), 32'h0);
        reset = 0;

        n_a = 0; n_b = 0;
        for (int i = 1; i <= 100 && n_a == 0; i++) begin
            cycle();
            if (!busy_b && n_b == 0) n_b = i;
            if (!busy_a && n_a == 0) n_a = i;
        end
        chk("init_len_64", 32'(n_a), 32'd64);
        chk("init_len_40", 32'(n_b), 32'd40);
        $display("init done: depth64 after %0d edges, depth40 after %0d edges", n_a, n_b);

        for (int i = 0; i < 64; i++) begin
            rd(AW'(i), 12'h100);
            chk("init_hold_a", 32'(target_a), 32'h100);
        end

        wr(6'd16, 12'd14, 1'b0);
        rd(6'd16, 12'h050);
        chk("rel_valid", 32'(valid_a), 32'h1);
        chk("rel_target", 32'(target_a), 32'h05E);
        rd(6'd16, 12'h050);
        chk("rel_back2back", 32'(valid_a), 32'h1);
        cycle();
        chk("valid_one_cycle", 32'(valid_a), 32'h0);
        chk("target_hold", 32'(target_a), 32'h05E);

        wr(6'd17, 12'hF71, 1'b0);
        rd(6'd17, 12'h020);
        chk("rel_wrap", 32'(target_a), 32'hF91);

        wr(6'd3, 12'h2A0, 1'b1);
        rd(6'd3, 12'h7FF);
        chk("abs_target", 32'(target_b), 32'h2A0);

        wr(6'd5, 12'd2, 1'b0);
        wr_en = 1; wr_addr = 6'd5; wr_data = 12'd7; wr_abs = 0;
        rd(6'd5, 12'h010);
        wr_en = 0;
`ifdef BTT_WR_BYPASS_EN
        chk("collide_bypass", 32'(target_a), 32'h017);
`else
        chk("collide_old", 32'(target_a), 32'h012);
`endif
        rd(6'd5, 12'h010);
        chk("collide_next", 32'(target_a), 32'h017);

        wr(6'd45, 12'd9, 1'b0);
        rd(6'd45, 12'h123);
        chk("oor_hold_40", 32'(target_b), 32'h123);
        chk("oor_stored_64", 32'(target_a), 32'h12C);

        rd(6'd16, 12'h050);
        reset = 1;
        cycle();
        chk("midrst_valid", 32'(valid_a), 32'h0);
        chk("midrst_target", 32'(target_a), 32'h0);
        chk("midrst_busy", 32'(busy_a), 32'h1);
        reset = 0;

        for (int i = 0; i < 100 && (busy_a || busy_b); i++) begin
            if (i < 30) begin
                wr_en = 1; wr_addr = AW'(i); wr_data = 12'($urandom); wr_abs = 1'($urandom);
                rd_req = 1'($urandom); rd_addr = AW'(i); pc = 12'h0AB;
            end else begin
                idle();
            end
            cycle();
        end
        idle();
        chk("reinit_done", 32'({busy_a, busy_b}), 32'h0);

        for (int i = 0; i < 64; i++) begin
            rd(AW'(i), 12'h321);
            chk("reinit_hold_a", 32'(target_a), 32'h321);
            chk("reinit_hold_b", 32'(target_b), 32'h321);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
